warp_fetch_issuer: RTL and testbench

Initiator side of the instruction-fetch stream. The block keeps a per-warp PC table and picks one eligible warp per cycle by round-robin. It drives the (warp_id, pc, tvalid, tlast) request beat into instruction_cache. It also takes the registered response (warp_id, instruction, tvalid, tlast) back and forwards it to decode, tagged with the PC that was fetched. Each warp has at most one instruction outstanding; decode or the branch unit retires it.

---
 rtl/warp_fetch_issuer_pkg.sv | 28 ++
 rtl/warp_fetch_issuer_if.sv | 25 ++
 rtl/warp_fetch_issuer_rr_arbiter.sv | 39 +++
 rtl/warp_fetch_issuer.sv | 147 ++++++++++++++
 tb/tb_warp_fetch_issuer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/warp_fetch_issuer_pkg.sv
// Shared types and constants for the warp instruction-fetch issuer.
// Warp count is derived from the id width so the two can never disagree.
package fetch_pkg;

  localparam int WID_W     = 5;
  localparam int NUM_WARPS = 2 ** WID_W;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef logic [WID_W-1:0] warp_id_t;

  typedef struct packed {
    warp_id_t    warp_id;
    logic [31:0] pc;
    logic        last;
  } fetch_req_t;

  typedef struct packed {
    warp_id_t    warp_id;
    logic [31:0] instruction;
    logic        last;
  } fetch_rsp_t;

  function automatic logic [NUM_WARPS-1:0] warp_onehot(input logic valid, input warp_id_t id);
    warp_onehot     = '0;
    warp_onehot[id] = valid;
  endfunction

endpackage

// File: rtl/warp_fetch_issuer_if.sv
// Request/response stream between the fetch issuer (master) and the instruction cache (slave).
interface warp_fetch_issuer_if;
  import fetch_pkg::*;

  logic        m_tvalid;
  logic        m_tlast;
  warp_id_t    m_warp_id;
  logic [31:0] m_pc;

  logic        s_tvalid;
  logic        s_tlast;
  warp_id_t    s_warp_id;
  logic [31:0] s_instruction;

  modport master (
    output m_tvalid, m_tlast, m_warp_id, m_pc,
    input  s_tvalid, s_tlast, s_warp_id, s_instruction
  );

  modport slave (
    input  m_tvalid, m_tlast, m_warp_id, m_pc,
    output s_tvalid, s_tlast, s_warp_id, s_instruction
  );

endinterface

// File: rtl/warp_fetch_issuer_rr_arbiter.sv
// Combinational round-robin pick over all warps, starting at rr_ptr.
// is_last flags a winner with no eligible warp above it (end of a sweep).
module rr_arbiter
  import fetch_pkg::*;
(
  input  logic [NUM_WARPS-1:0] elig,
  input  warp_id_t             rr_ptr,
  output logic                 grant_valid,
  output warp_id_t             grant_id,
  output logic                 is_last
);

  warp_id_t idx;
  logic     higher;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = '0;
    // scanning from the far end lets the closest eligible warp overwrite the rest
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      idx = rr_ptr + warp_id_t'(i);
      if (elig[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    higher = 1'b0;
    for (int j = 0; j < NUM_WARPS; j++) begin
      if (elig[j] && (warp_id_t'(j) > grant_id)) higher = 1'b1;
    end
  end

  assign is_last = grant_valid & ~higher;

endmodule

// File: rtl/warp_fetch_issuer.sv
// Per-warp PC table with round-robin fetch issue and tagged response forwarding to decode.
// Each warp has at most one instruction outstanding until done/redirect retires it.
module warp_fetch_issuer
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        launch_valid,
  input  warp_id_t    launch_warp_id,
  input  logic [31:0] launch_pc,
  input  logic        exit_valid,
  input  warp_id_t    exit_warp_id,
  input  logic        done_valid,
  input  warp_id_t    done_warp_id,
  input  logic        redir_valid,
  input  warp_id_t    redir_warp_id,
  input  logic [31:0] redir_pc,
  warp_fetch_issuer_if.master bus,
  output logic        dec_valid,
  output logic        dec_last,
  output warp_id_t    dec_warp_id,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instruction
);

  logic [NUM_WARPS-1:0] active_q;
  logic [NUM_WARPS-1:0] in_flight_q;
  logic [NUM_WARPS-1:0] elig;
  logic [31:0]          pc_q       [NUM_WARPS];
  logic [31:0]          fetch_pc_q [NUM_WARPS];
  warp_id_t             rr_ptr_q;

  logic     grant_valid;
  logic     grant_last;
  warp_id_t grant_id;

  logic [NUM_WARPS-1:0] launch_hit;
  logic [NUM_WARPS-1:0] exit_hit;
  logic [NUM_WARPS-1:0] redir_hit;
  logic [NUM_WARPS-1:0] done_hit;
  logic [NUM_WARPS-1:0] issue_hit;

  fetch_req_t  req_q;
  logic        req_valid_q;
  fetch_rsp_t  dec_q;
  logic        dec_valid_q;
  logic [31:0] dec_pc_q;
  logic        rsp_kill;
  logic        rsp_accept;

  assign elig = {NUM_WARPS{fetch_en}} & active_q & ~in_flight_q;

  rr_arbiter u_arb (
    .elig        (elig),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .is_last     (grant_last)
  );

  assign launch_hit = warp_onehot(launch_valid, launch_warp_id);
  assign exit_hit   = warp_onehot(exit_valid, exit_warp_id);
  assign redir_hit  = warp_onehot(redir_valid, redir_warp_id);
  assign done_hit   = warp_onehot(done_valid, done_warp_id);
  assign issue_hit  = warp_onehot(grant_valid, grant_id);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_q <= 1'b0;
      req_q       <= '0;
      rr_ptr_q    <= '0;
    end else begin
      req_valid_q <= grant_valid;
      req_q.last  <= grant_last;
      if (grant_valid) begin
        req_q.warp_id <= grant_id;
        req_q.pc      <= pc_q[grant_id];
        rr_ptr_q      <= grant_id + 1'b1;
      end
    end
  end

  // launch > exit > redir > done > issue; a done for an idle warp must not mask an issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= '0;
      in_flight_q <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_q[w]       <= '0;
        fetch_pc_q[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (issue_hit[w]) fetch_pc_q[w] <= pc_q[w];
        if (launch_hit[w]) begin
          active_q[w]    <= 1'b1;
          pc_q[w]        <= launch_pc;
          in_flight_q[w] <= 1'b0;
        end else if (exit_hit[w]) begin
          active_q[w]    <= 1'b0;
          in_flight_q[w] <= 1'b0;
        end else if (redir_hit[w]) begin
          pc_q[w]        <= redir_pc;
          in_flight_q[w] <= 1'b0;
        end else if (done_hit[w] && in_flight_q[w]) begin
          in_flight_q[w] <= 1'b0;
        end else if (issue_hit[w]) begin
          pc_q[w]        <= pc_q[w] + PC_STEP;
          in_flight_q[w] <= 1'b1;
        end
      end
    end
  end

  // a response whose warp is being retired this very cycle is stale as well
  assign rsp_kill   = launch_hit[bus.s_warp_id] | exit_hit[bus.s_warp_id] | redir_hit[bus.s_warp_id];
  assign rsp_accept = bus.s_tvalid & in_flight_q[bus.s_warp_id] & ~rsp_kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid_q <= 1'b0;
      dec_q       <= '0;
      dec_pc_q    <= '0;
    end else begin
      dec_valid_q <= rsp_accept;
      if (rsp_accept) begin
        dec_q.warp_id     <= bus.s_warp_id;
        dec_q.instruction <= bus.s_instruction;
        dec_q.last        <= bus.s_tlast;
        dec_pc_q          <= fetch_pc_q[bus.s_warp_id];
      end
    end
  end

  assign bus.m_tvalid  = req_valid_q;
  assign bus.m_tlast   = req_q.last;
  assign bus.m_warp_id = req_q.warp_id;
  assign bus.m_pc      = req_q.pc;

  assign dec_valid       = dec_valid_q;
  assign dec_last        = dec_q.last;
  assign dec_warp_id     = dec_q.warp_id;
  assign dec_pc          = dec_pc_q;
  assign dec_instruction = dec_q.instruction;

endmodule

// File: tb/tb_warp_fetch_issuer.sv
// Bench for warp_fetch_issuer: directed scenarios plus random traffic against a behavioural model,
// with a one-cycle loopback cache.
module tb_warp_fetch_issuer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        launch_valid = 1'b0;
  warp_id_t    launch_warp_id = '0;
  logic [31:0] launch_pc = '0;
  logic        exit_valid = 1'b0;
  warp_id_t    exit_warp_id = '0;
  logic        done_valid = 1'b0;
  warp_id_t    done_warp_id = '0;
  logic        redir_valid = 1'b0;
  warp_id_t    redir_warp_id = '0;
  logic [31:0] redir_pc = '0;
  logic        dec_valid, dec_last;
  warp_id_t    dec_warp_id;
  logic [31:0] dec_pc, dec_instruction;

  always #5 clk = ~clk;

  warp_fetch_issuer_if bus();

  warp_fetch_issuer dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .launch_valid(launch_valid), .launch_warp_id(launch_warp_id), .launch_pc(launch_pc),
    .exit_valid(exit_valid), .exit_warp_id(exit_warp_id),
    .done_valid(done_valid), .done_warp_id(done_warp_id),
    .redir_valid(redir_valid), .redir_warp_id(redir_warp_id), .redir_pc(redir_pc),
    .bus(bus),
    .dec_valid(dec_valid), .dec_last(dec_last), .dec_warp_id(dec_warp_id),
    .dec_pc(dec_pc), .dec_instruction(dec_instruction)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // behavioural model state
  bit          mdl_act [NUM_WARPS];
  bit          mdl_fl  [NUM_WARPS];
  logic [31:0] mdl_pc  [NUM_WARPS];
  logic [31:0] mdl_fpc [NUM_WARPS];
  int          mdl_ptr;
  logic        e_mv, e_ml, e_dv, e_dl;
  logic [WID_W-1:0] e_mw, e_dw;
  logic [31:0] e_mpc, e_dpc, e_di;

  // cache loopback pipeline and bookkeeping
  logic        p_v, p_l;
  logic [WID_W-1:0] p_w;
  int          dq[$];
  int          beats[$];

  task automatic model_reset();
    for (int w = 0; w < NUM_WARPS; w++) begin
      mdl_act[w] = 0; mdl_fl[w] = 0; mdl_pc[w] = '0; mdl_fpc[w] = '0;
    end
    mdl_ptr = 0;
    e_mv = 0; e_ml = 0; e_mw = '0; e_mpc = '0;
    e_dv = 0; e_dl = 0; e_dw = '0; e_dpc = '0; e_di = '0;
    p_v = 0; p_l = 0; p_w = '0;
    bus.s_tvalid = 0; bus.s_tlast = 0; bus.s_warp_id = '0; bus.s_instruction = '0;
    dq.delete();
  endtask

  function automatic bit eligible(int w);
    return fetch_en && mdl_act[w] && !mdl_fl[w];
  endfunction

  task automatic model_step();
    int  win, w;
    bit  lst, kill;
    win = -1;
    for (int i = 0; i < NUM_WARPS; i++) begin
      w = (mdl_ptr + i) % NUM_WARPS;
      if (win < 0 && eligible(w)) win = w;
    end
    lst = (win >= 0);
    for (int j = 0; j < NUM_WARPS; j++)
      if (win >= 0 && j > win && eligible(j)) lst = 0;
    e_mv = (win >= 0);
    e_ml = lst;
    if (win >= 0) begin
      e_mw  = WID_W'(win);
      e_mpc = mdl_pc[win];
    end

    w = int'(bus.s_warp_id);
    kill = (launch_valid && launch_warp_id == bus.s_warp_id) ||
           (exit_valid && exit_warp_id == bus.s_warp_id) ||
           (redir_valid && redir_warp_id == bus.s_warp_id);
    e_dv = bus.s_tvalid && mdl_fl[w] && !kill;
    if (e_dv) begin
      e_dw = bus.s_warp_id; e_di = bus.s_instruction; e_dl = bus.s_tlast; e_dpc = mdl_fpc[w];
      dq.push_back(w);
    end

    if (win >= 0) begin
      mdl_fpc[win] = mdl_pc[win];
      mdl_ptr = (win + 1) % NUM_WARPS;
    end
    for (int k = 0; k < NUM_WARPS; k++) begin
      if (launch_valid && int'(launch_warp_id) == k) begin
        mdl_act[k] = 1; mdl_pc[k] = launch_pc; mdl_fl[k] = 0;
      end else if (exit_valid && int'(exit_warp_id) == k) begin
        mdl_act[k] = 0; mdl_fl[k] = 0;
      end else if (redir_valid && int'(redir_warp_id) == k) begin
        mdl_pc[k] = redir_pc; mdl_fl[k] = 0;
      end else if (done_valid && int'(done_warp_id) == k && mdl_fl[k]) begin
        mdl_fl[k] = 0;
      end else if (win == k) begin
        mdl_pc[k] = mdl_pc[k] + 32'd4; mdl_fl[k] = 1;
      end
    end
  endtask

  task automatic compare_outputs();
    chk("m_tvalid", bus.m_tvalid, e_mv);
    chk("m_tlast", bus.m_tlast, e_ml);
    chk("m_warp_id", bus.m_warp_id, e_mw);
    chk("m_pc", bus.m_pc, e_mpc);
    chk("dec_valid", dec_valid, e_dv);
    chk("dec_last", dec_last, e_dl);
    chk("dec_warp_id", dec_warp_id, e_dw);
    chk("dec_pc", dec_pc, e_dpc);
    chk("dec_instruction", dec_instruction, e_di);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
    if (bus.m_tvalid) beats.push_back(int'(bus.m_warp_id) * 2 + int'(bus.m_tlast));
    bus.s_tvalid = p_v; bus.s_tlast = p_l; bus.s_warp_id = p_w;
    bus.s_instruction = $urandom;
    p_v = bus.m_tvalid; p_l = bus.m_tlast; p_w = bus.m_warp_id;
    launch_valid = 0; exit_valid = 0; redir_valid = 0; done_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    launch_valid = 0; exit_valid = 0; redir_valid = 0; done_valid = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic launch(input int w, input logic [31:0] pc);
    launch_valid = 1; launch_warp_id = WID_W'(w); launch_pc = pc;
    cycle();
  endtask

  task automatic random_cycle();
    fetch_en = ($urandom_range(0, 15) != 0);
    if ($urandom_range(0, 7) == 0) begin
      launch_valid = 1; launch_warp_id = WID_W'($urandom);
      launch_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & ~32'h3);
    end
    if ($urandom_range(0, 39) == 0) begin
      exit_valid = 1; exit_warp_id = WID_W'($urandom);
    end
    if ($urandom_range(0, 19) == 0) begin
      redir_valid = 1; redir_warp_id = WID_W'($urandom); redir_pc = $urandom & ~32'h3;
    end
    if (dq.size() > 0 && $urandom_range(0, 1) == 0) begin
      done_valid = 1; done_warp_id = WID_W'(dq.pop_front());
    end else if ($urandom_range(0, 29) == 0) begin
      done_valid = 1; done_warp_id = WID_W'($urandom);
    end
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rr[3];
    exp_rr[0] = 0; exp_rr[1] = 10; exp_rr[2] = 63;
    model_reset();
    repeat (2) @(negedge clk);
    compare_outputs();
    rst_n = 1;

    // single warp
    do_reset(); fetch_en = 1;
    launch(3, 32'h1000);
    cycle();
    chk("sw_tvalid", bus.m_tvalid, 1); chk("sw_wid", bus.m_warp_id, 3);
    chk("sw_pc", bus.m_pc, 32'h1000);  chk("sw_last", bus.m_tlast, 1);
    cycle(); cycle();
    chk("sw_dec_valid", dec_valid, 1); chk("sw_dec_pc", dec_pc, 32'h1000);
    done_valid = 1; done_warp_id = 3; cycle();
    cycle();
    chk("sw_next_tvalid", bus.m_tvalid, 1); chk("sw_next_pc", bus.m_pc, 32'h1004);

    // round robin over 0, 5, 31
    do_reset(); fetch_en = 0;
    launch(0, 32'h100); launch(5, 32'h500); launch(31, 32'h3100);
    for (int pass = 0; pass < 2; pass++) begin
      beats.delete(); fetch_en = 1;
      repeat (3) cycle();
      chk("rr_count", beats.size(), 3);
      for (int i = 0; i < 3; i++) chk("rr_beat", (i < beats.size()) ? beats[i] : -1, exp_rr[i]);
      fetch_en = 0;
      repeat (3) cycle();
      done_valid = 1; done_warp_id = 0;  cycle();
      done_valid = 1; done_warp_id = 5;  cycle();
      done_valid = 1; done_warp_id = 31; cycle();
    end

    // redirect together with done
    do_reset(); fetch_en = 1;
    launch(2, 32'h1000);
    cycle(); chk("rd_first_pc", bus.m_pc, 32'h1000);
    cycle(); cycle();
    redir_valid = 1; redir_warp_id = 2; redir_pc = 32'h2000;
    done_valid = 1; done_warp_id = 2; cycle();
    cycle();
    chk("rd_tvalid", bus.m_tvalid, 1); chk("rd_wid", bus.m_warp_id, 2); chk("rd_pc", bus.m_pc, 32'h2000);

    // exit during the response cycle drops the response
    do_reset(); fetch_en = 1;
    launch(7, 32'h7000);
    cycle(); chk("ex_tvalid", bus.m_tvalid, 1); chk("ex_wid", bus.m_warp_id, 7);
    cycle();
    exit_valid = 1; exit_warp_id = 7; cycle();
    chk("ex_dec_dropped", dec_valid, 0);
    beats.delete(); repeat (6) cycle();
    chk("ex_no_reissue", beats.size(), 0);

    // PC wrap and fetch enable
    do_reset(); fetch_en = 1;
    launch(9, 32'hFFFF_FFFC);
    cycle(); chk("wr_pc", bus.m_pc, 32'hFFFF_FFFC);
    fetch_en = 0;
    cycle(); cycle();
    chk("wr_dec_valid", dec_valid, 1); chk("wr_dec_pc", dec_pc, 32'hFFFF_FFFC);
    done_valid = 1; done_warp_id = 9; cycle();
    cycle(); chk("en_blocked", bus.m_tvalid, 0);
    fetch_en = 1; cycle();
    chk("wr_tvalid", bus.m_tvalid, 1); chk("wr_next_pc", bus.m_pc, 32'h0);

    // random traffic
    do_reset();
    repeat (3000) random_cycle();

    // reset in the middle of traffic
    fetch_en = 1;
    for (int w = 0; w < 4; w++) launch(w * 8, 32'h4000 + 32'(w) * 32'h100);
    for (int i = 0; i < 50 && !bus.m_tvalid; i++) cycle();
    chk("rst_pre_tvalid", bus.m_tvalid, 1);
    rst_n = 0; #1;
    model_reset();
    compare_outputs();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    beats.delete();
    repeat (10) cycle();
    chk("rst_no_issue", beats.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
